mem_bus_ctrl: RTL

// - Memory/IO bus stage directly downstream of the cpu. Consumes mem_cmd, mem_addr and write_data; returns read_data.
// - Decodes the 9-bit word address into three targets: 256x16 synchronous RAM, an LED output register and a switch input port.
// - Read data comes back with fixed 1-cycle latency, qualified by rd_valid. Unmapped or illegal accesses set a sticky bus_err flag.

---
 rtl/mem_bus_ctrl_pkg.sv | 20 ++
 rtl/mem_bus_ctrl_if.sv | 24 ++
 rtl/mem_bus_ctrl_ram.sv | 25 ++
 rtl/mem_bus_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// rtl/mem_bus_ctrl_pkg.sv - shared bus command, address map and read-source types
package bus_pkg;

   typedef enum logic [1:0] {
      MNONE    = 2'b00,
      MREAD    = 2'b01,
      MWRITE   = 2'b10,
      MILLEGAL = 2'b11
   } mem_cmd_t;

   typedef enum logic [1:0] {
      SRC_RAM  = 2'b00,
      SRC_SW   = 2'b01,
      SRC_ZERO = 2'b10
   } rd_src_t;

   localparam logic [8:0] LED_ADDR = 9'h100;
   localparam logic [8:0] SW_ADDR  = 9'h140;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - cpu-to-memory bus bundle with master/slave views
interface mem_bus_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9
);
   import bus_pkg::*;

   mem_cmd_t            mem_cmd;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   write_data;
   logic [DATA_W-1:0]   read_data;
   logic                rd_valid;

   modport master (
      output mem_cmd, mem_addr, write_data,
      input  read_data, rd_valid
   );

   modport slave (
      input  mem_cmd, mem_addr, write_data,
      output read_data, rd_valid
   );

endinterface

// File: rtl/mem_bus_ctrl_ram.sv
// rtl/mem_bus_ctrl_ram.sv - single-port RAM, synchronous write, registered read
module ram #(
   parameter int    DATA_W    = 16,
   parameter int    RAM_AW    = 8,
   parameter string INIT_FILE = "data.txt"
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [RAM_AW-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**RAM_AW];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - bus decode to RAM / LED register / switch port with 1-cycle read return
module mem_bus_ctrl
   import bus_pkg::*;
#(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 9,
   parameter int                RAM_AW    = 8,
   parameter logic [ADDR_W-1:0] LED_ADDR  = bus_pkg::LED_ADDR,
   parameter logic [ADDR_W-1:0] SW_ADDR   = bus_pkg::SW_ADDR,
   parameter string             INIT_FILE = "data.txt"
) (
   input  logic       clk,
   input  logic       reset,
   mem_bus_if.slave   bus,
   input  logic [7:0] SW,
   output logic [7:0] LEDR,
   output logic       bus_err
);

   logic              is_ram, is_led, is_sw;
   logic              ram_we_d, ram_re_d, led_we_d, err_set_d, rd_valid_d;
   rd_src_t           rd_src_d;

   rd_src_t           rd_src_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [7:0]        led_q;
   logic              err_q;
   logic [7:0]        sw_meta_q, sw_sync_q;

   logic [DATA_W-1:0] ram_dout;
   logic [DATA_W-1:0] rsp_data;

   assign is_ram = ~bus.mem_addr[ADDR_W-1];
   assign is_led = (bus.mem_addr == LED_ADDR);
   assign is_sw  = (bus.mem_addr == SW_ADDR);

   always_comb begin
      ram_we_d   = 1'b0;
      ram_re_d   = 1'b0;
      led_we_d   = 1'b0;
      err_set_d  = 1'b0;
      rd_valid_d = 1'b0;
      rd_src_d   = SRC_ZERO;
      case (bus.mem_cmd)
         MREAD: begin
            rd_valid_d = 1'b1;
            if (is_ram) begin
               ram_re_d = 1'b1;
               rd_src_d = SRC_RAM;
            end else if (is_sw) begin
               rd_src_d = SRC_SW;
            end else begin
               err_set_d = 1'b1;
            end
         end
         MWRITE: begin
            if (is_ram)      ram_we_d  = 1'b1;
            else if (is_led) led_we_d  = 1'b1;
            else             err_set_d = 1'b1;
         end
         MILLEGAL: err_set_d = 1'b1;
         default: ;
      endcase
   end

   // Reset must also block the RAM write that would otherwise land this edge.
   ram #(
      .DATA_W    (DATA_W),
      .RAM_AW    (RAM_AW),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we_d & ~reset),
      .re_i    (ram_re_d & ~reset),
      .addr_i  (bus.mem_addr[RAM_AW-1:0]),
      .wdata_i (bus.write_data),
      .rdata_o (ram_dout)
   );

   always_comb begin
      rsp_data = '0;
      case (rd_src_q)
         SRC_RAM: rsp_data = ram_dout;
         SRC_SW:  rsp_data = {{(DATA_W-8){1'b0}}, sw_sync_q};
         default: rsp_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_src_q   <= SRC_ZERO;
         rdata_q    <= '0;
         led_q      <= '0;
         err_q      <= 1'b0;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_src_q   <= rd_src_d;
         rdata_q    <= bus.read_data;
         sw_meta_q  <= SW;
         sw_sync_q  <= sw_meta_q;
         err_q      <= err_q | err_set_d;
         if (led_we_d) led_q <= bus.write_data[7:0];
      end
   end

   // rdata_q tracks the presented value so read_data holds between responses.
   assign bus.read_data = rd_valid_q ? rsp_data : rdata_q;
   assign bus.rd_valid  = rd_valid_q;
   assign LEDR          = led_q;
   assign bus_err       = err_q;

endmodule
